// File: rtl/channel_cu_responder.sv
// Control-unit-side responder for the Parallel Channel: answers selection for one address and
// runs write/read/NOP/test commands against a small loop buffer, then presents ending status.
module channel_cu_responder #(
    parameter logic [7:0]  ADDRESS    = 8'h00,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            bus_out,
    input  logic                  bus_out_parity,
    input  logic                  operational_out,
    input  logic                  select_out,
    input  logic                  address_out,
    input  logic                  command_out,
    input  logic                  service_out,
    output logic [7:0]            bus_in,
    output logic                  bus_in_parity,
    output logic                  operational_in,
    output logic                  select_in,
    output logic                  address_in,
    output logic                  status_in,
    output logic                  service_in,
    output logic [DEPTH_LOG2:0]   byte_count,
    output logic                  busy
);

    localparam int unsigned         Depth     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [7:0] CmdTest   = 8'h00;
    localparam logic [7:0] CmdWrite  = 8'h01;
    localparam logic [7:0] CmdRead   = 8'h02;
    localparam logic [7:0] CmdNop    = 8'h03;
    localparam logic [7:0] StatusEnd = 8'h0C;
    localparam logic [7:0] StatusUc  = 8'h02;

    typedef enum logic [2:0] {
        StIdle, StAddr, StCmdDrop, StData, StDataDrop, StStopDrop, StStatus, StDisc
    } state_e;

    state_e                state_q;
    logic [7:0]            cmd_q;
    logic                  cmd_perr_q;
    logic                  is_read_q;
    logic                  unit_check_q;
    logic [DEPTH_LOG2:0]   rd_ptr_q;
    logic [7:0]            buf_q [Depth];

    logic addr_match;
    logic buf_wr;

    assign addr_match = address_out & select_out & (bus_out == ADDRESS)
                        & (^{bus_out, bus_out_parity});
    assign buf_wr = operational_out & (state_q == StData) & ~is_read_q & ~command_out
                    & service_out & service_in;

    // Odd parity holds even while bus_in is idle at zero.
    assign bus_in_parity = ~^bus_in;
    assign busy          = (state_q != StIdle);

    // Entries at or beyond byte_count are never presented, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            buf_q[byte_count[DEPTH_LOG2-1:0]] <= bus_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            cmd_q          <= '0;
            cmd_perr_q     <= 1'b0;
            is_read_q      <= 1'b0;
            unit_check_q   <= 1'b0;
            rd_ptr_q       <= '0;
            byte_count     <= '0;
            bus_in         <= '0;
            operational_in <= 1'b0;
            select_in      <= 1'b0;
            address_in     <= 1'b0;
            status_in      <= 1'b0;
            service_in     <= 1'b0;
        end else if (!operational_out) begin
            state_q        <= StIdle;
            is_read_q      <= 1'b0;
            unit_check_q   <= 1'b0;
            rd_ptr_q       <= '0;
            byte_count     <= '0;
            bus_in         <= '0;
            operational_in <= 1'b0;
            select_in      <= 1'b0;
            address_in     <= 1'b0;
            status_in      <= 1'b0;
            service_in     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (addr_match) begin
                        operational_in <= 1'b1;
                        select_in      <= 1'b0;
                        address_in     <= 1'b1;
                        bus_in         <= ADDRESS;
                        state_q        <= StAddr;
                    end else begin
                        select_in <= select_out;
                    end
                end
                StAddr: begin
                    if (command_out) begin
                        cmd_q      <= bus_out;
                        cmd_perr_q <= ~^{bus_out, bus_out_parity};
                        address_in <= 1'b0;
                        bus_in     <= '0;
                        state_q    <= StCmdDrop;
                    end
                end
                StCmdDrop: begin
                    if (!command_out) begin
                        rd_ptr_q  <= '0;
                        is_read_q <= 1'b0;
                        if (cmd_perr_q) begin
                            unit_check_q <= 1'b1;
                            state_q      <= StStatus;
                        end else begin
                            case (cmd_q)
                                CmdWrite: begin
                                    byte_count <= '0;
                                    state_q    <= StData;
                                end
                                CmdRead: begin
                                    is_read_q <= 1'b1;
                                    state_q   <= (byte_count == '0) ? StStatus : StData;
                                end
                                CmdNop, CmdTest: state_q <= StStatus;
                                default: begin
                                    unit_check_q <= 1'b1;
                                    state_q      <= StStatus;
                                end
                            endcase
                        end
                    end
                end
                StData: begin
                    // Stop takes priority over a concurrent service response.
                    if (command_out) begin
                        service_in <= 1'b0;
                        bus_in     <= '0;
                        state_q    <= StStopDrop;
                    end else if (service_out && service_in) begin
                        if (is_read_q) begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end else begin
                            byte_count <= byte_count + 1'b1;
                        end
                        service_in <= 1'b0;
                        bus_in     <= '0;
                        state_q    <= StDataDrop;
                    end else begin
                        service_in <= 1'b1;
                        bus_in     <= is_read_q ? buf_q[rd_ptr_q[DEPTH_LOG2-1:0]] : 8'h00;
                    end
                end
                StDataDrop: begin
                    if (!service_out) begin
                        if (!is_read_q && byte_count == FullCount) begin
                            unit_check_q <= 1'b1;
                            state_q      <= StStatus;
                        end else if (is_read_q && rd_ptr_q == byte_count) begin
                            state_q <= StStatus;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StStopDrop: begin
                    if (!command_out) begin
                        state_q <= StStatus;
                    end
                end
                StStatus: begin
                    if (status_in && (service_out || command_out)) begin
                        status_in    <= 1'b0;
                        bus_in       <= '0;
                        unit_check_q <= 1'b0;
                        state_q      <= StDisc;
                    end else begin
                        status_in <= 1'b1;
                        bus_in    <= StatusEnd | (unit_check_q ? StatusUc : 8'h00);
                    end
                end
                StDisc: begin
                    if (!service_out && !command_out && !select_out) begin
                        operational_in <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_cu_responder.sv
// Randomized scoreboard bench for channel_cu_responder: a channel-side driver issues
// selections and commands while a monitor checks every tag the responder raises.
module tb_channel_cu_responder;

    localparam logic [7:0] Addr = 8'h41;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] bus_out;
    logic       bus_out_parity;
    logic       operational_out;
    logic       select_out;
    logic       address_out;
    logic       command_out;
    logic       service_out;
    logic [7:0] bus_in;
    logic       bus_in_parity;
    logic       operational_in;
    logic       select_in;
    logic       address_in;
    logic       status_in;
    logic       service_in;
    logic [4:0] byte_count;
    logic       busy;

    channel_cu_responder #(.ADDRESS(Addr), .DEPTH_LOG2(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus_out(bus_out), .bus_out_parity(bus_out_parity),
        .operational_out(operational_out), .select_out(select_out), .address_out(address_out),
        .command_out(command_out), .service_out(service_out), .bus_in(bus_in),
        .bus_in_parity(bus_in_parity), .operational_in(operational_in), .select_in(select_in),
        .address_in(address_in), .status_in(status_in), .service_in(service_in),
        .byte_count(byte_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected tag events: 0 = address_in, 1 = service_in, 2 = status_in.
    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] mbuf [16];
    int         mcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected event kind=%0d: got bus_in=%0h expected no event",
                     kind, bus_in);
        end else begin
            e = sb.pop_front();
            chk("event kind", kind, e.kind);
            chk("bus_in", bus_in, e.val);
            chk("bus_in_parity", bus_in_parity, ~^e.val);
        end
    endtask

    logic p_addr = 1'b0, p_svc = 1'b0, p_stat = 1'b0;
    always @(negedge clk) begin
        if (address_in && !p_addr) check_event(0);
        if (service_in && !p_svc)  check_event(1);
        if (status_in && !p_stat)  check_event(2);
        p_addr <= address_in;
        p_svc  <= service_in;
        p_stat <= status_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tag(input int w);
        case (w)
            0:       return address_in;
            1:       return service_in;
            2:       return status_in;
            3:       return operational_in;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_tag(input int w, input logic lvl, input string nm);
        int n = 0;
        while (tag(w) !== lvl && n < 64) begin
            tick();
            n++;
        end
        if (tag(w) !== lvl) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: got %0b expected %0b", nm, tag(w), lvl);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic select_dev(input logic [7:0] a, input logic good);
        logic hit;
        hit = (a == Addr) && good;
        if (hit) push(0, Addr);
        bus_out        = a;
        bus_out_parity = good ? ~^a : ^a;
        address_out    = 1'b1;
        select_out     = 1'b1;
        tick();
        if (hit) begin
            chk("operational_in on match", operational_in, 1);
            chk("select_in held on match", select_in, 0);
            address_out = 1'b0;
        end else begin
            chk("select_in propagated", select_in, 1);
            chk("operational_in on non-match", operational_in, 0);
            address_out = 1'b0;
            select_out  = 1'b0;
            tick();
            chk("select_in dropped", select_in, 0);
        end
    endtask

    task automatic issue_cmd(input logic [7:0] c, input logic good);
        bus_out        = c;
        bus_out_parity = good ? ~^c : ^c;
        command_out    = 1'b1;
        wait_tag(0, 1'b0, "address_in drop");
        command_out = 1'b0;
        bus_out     = 8'h00;
        tick();
    endtask

    task automatic finish_status();
        wait_tag(2, 1'b1, "status_in");
        if ($urandom_range(0, 1) == 1) command_out = 1'b1;
        else service_out = 1'b1;
        wait_tag(2, 1'b0, "status_in drop");
        service_out = 1'b0;
        command_out = 1'b0;
        select_out  = 1'b0;
        wait_tag(3, 1'b0, "operational_in drop");
        chk("busy after disconnect", busy, 0);
    endtask

    // Write n bytes; stop ends with command_out, otherwise n must be 16 (overflow).
    task automatic run_write(input int n, input logic stop, input logic fixed);
        logic [7:0] b;
        select_dev(Addr, 1'b1);
        for (int i = 0; i < n; i++) push(1, 8'h00);
        if (stop) push(1, 8'h00);
        push(2, stop ? 8'h0C : 8'h0E);
        issue_cmd(8'h01, 1'b1);
        mcnt = 0;
        for (int i = 0; i < n; i++) begin
            b = fixed ? ((i == 0) ? 8'hA5 : 8'h5A) : 8'($urandom);
            wait_tag(1, 1'b1, "write service_in");
            bus_out     = b;
            service_out = 1'b1;
            wait_tag(1, 1'b0, "write service_in drop");
            service_out = 1'b0;
            bus_out     = 8'h00;
            mbuf[mcnt]  = b;
            mcnt++;
        end
        if (stop) begin
            wait_tag(1, 1'b1, "service_in before stop");
            command_out = 1'b1;
            wait_tag(1, 1'b0, "service_in drop on stop");
            command_out = 1'b0;
        end
        finish_status();
        chk("byte_count after write", byte_count, mcnt);
    endtask

    task automatic run_read();
        select_dev(Addr, 1'b1);
        for (int i = 0; i < mcnt; i++) push(1, mbuf[i]);
        push(2, 8'h0C);
        issue_cmd(8'h02, 1'b1);
        for (int i = 0; i < mcnt; i++) begin
            wait_tag(1, 1'b1, "read service_in");
            service_out = 1'b1;
            wait_tag(1, 1'b0, "read service_in drop");
            service_out = 1'b0;
        end
        finish_status();
        chk("byte_count after read", byte_count, mcnt);
    endtask

    task automatic run_simple(input logic [7:0] c, input logic good);
        select_dev(Addr, 1'b1);
        push(2, (good && (c == 8'h00 || c == 8'h03)) ? 8'h0C : 8'h0E);
        issue_cmd(c, good);
        finish_status();
    endtask

    task automatic check_all_low(input string nm);
        chk(nm, {bus_in, address_in, status_in, service_in, operational_in, select_in,
                 byte_count, busy}, 0);
        chk({nm, " parity"}, bus_in_parity, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic       g;
        reset_n = 1'b0;
        operational_out = 1'b0;
        bus_out = 8'h00;
        bus_out_parity = 1'b1;
        select_out = 1'b0;
        address_out = 1'b0;
        command_out = 1'b0;
        service_out = 1'b0;
        tick();
        tick();
        check_all_low("reset state");
        reset_n = 1'b1;
        operational_out = 1'b1;
        tick();

        select_dev(8'h42, 1'b1);
        run_write(2, 1'b1, 1'b1);
        run_read();
        run_simple(8'h07, 1'b1);
        run_simple(8'h03, 1'b0);
        run_simple(8'h03, 1'b1);
        run_simple(8'h00, 1'b1);
        run_write(0, 1'b1, 1'b0);
        run_read();
        run_write(16, 1'b0, 1'b0);
        run_read();

        // Channel drops operational_out during the data phase.
        select_dev(Addr, 1'b1);
        push(1, 8'h00);
        issue_cmd(8'h01, 1'b1);
        wait_tag(1, 1'b1, "service_in before op drop");
        operational_out = 1'b0;
        tick();
        check_all_low("op drop abort");
        sb.delete();
        mcnt = 0;
        select_out = 1'b0;
        operational_out = 1'b1;
        tick();

        // Reset asserted mid-read.
        run_write(3, 1'b1, 1'b0);
        select_dev(Addr, 1'b1);
        push(1, mbuf[0]);
        issue_cmd(8'h02, 1'b1);
        wait_tag(1, 1'b1, "service_in before reset");
        reset_n = 1'b0;
        #1;
        check_all_low("reset abort");
        sb.delete();
        mcnt = 0;
        select_out = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        run_write(2, 1'b1, 1'b1);
        run_read();

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 6))
                0: begin
                    a = 8'($urandom);
                    g = 1'($urandom_range(0, 1));
                    if (a == Addr && g) a = a ^ 8'h01;
                    select_dev(a, g);
                end
                1: run_write($urandom_range(0, 15), 1'b1, 1'b0);
                2: run_write(16, 1'b0, 1'b0);
                3: run_read();
                4: run_simple(($urandom_range(0, 1) == 1) ? 8'h03 : 8'h00, 1'b1);
                5: run_simple(8'($urandom_range(4, 255)), 1'b1);
                default: run_simple(8'($urandom_range(0, 3)), 1'b0);
            endcase
        end

        tick();
        chk("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
